// File: rtl/maze_player_ctrl_if.sv
// Wall-map lookup bus: the controller presents a tile address, the level map
// answers combinationally with that tile's wall bits {top, bottom, left, right}.
interface maze_player_ctrl_if;
    logic [4:0] q_row;
    logic [4:0] q_col;
    logic [3:0] q_walls;

    modport master (output q_row, output q_col, input q_walls);
    modport slave  (input q_row, input q_col, output q_walls);
endinterface

// File: rtl/maze_player_ctrl.sv
// Player block controller: synchronises buttons, validates moves against the
// wall map, and animates the block one tile at a time on frame ticks.
module maze_player_ctrl #(
    parameter int STEP      = 2,
    parameter int BLK_SIZE  = 10,
    parameter int Y_ORIGIN  = 100,
    parameter int START_ROW = 0,
    parameter int START_COL = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               frame_tick,
    input  logic [1:0]         level_select,
    input  logic [9:0]         tile_w,
    input  logic [9:0]         tile_h,
    input  logic [4:0]         num_rows,
    input  logic [4:0]         num_cols,
    maze_player_ctrl_if.master wall_if,
    output logic [10:0]        blkpos_x,
    output logic [10:0]        blkpos_y,
    output logic               moving,
    output logic               goal_pulse
);

    typedef enum logic [1:0] {S_IDLE, S_QUERY, S_CHECK, S_MOVE} state_e;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

    localparam logic [4:0]  START_ROW_L = 5'(START_ROW);
    localparam logic [4:0]  START_COL_L = 5'(START_COL);
    localparam logic [11:0] STEP_L      = 12'(STEP);

    // Screen coordinate of the block edge along one axis, centred in the tile.
    function automatic logic [10:0] axis_pos(input logic [4:0] idx, input logic [9:0] size,
                                             input logic [11:0] off, input int origin);
        return 11'(16'(origin) + 16'(idx) * 16'(size) + 16'(size >> 1)
                   - 16'(BLK_SIZE / 2) + {{4{off[11]}}, off});
    endfunction

    logic [3:0]  btn_meta_q, btn_sync_q, btn_prev_q;
    logic [3:0]  press;
    state_e      state_q, state_d;
    dir_e        dir_q, dir_d;
    logic [4:0]  row_q, row_d, col_q, col_d;
    logic [4:0]  q_row_q, q_row_d, q_col_q, q_col_d;
    logic [11:0] mag_q, mag_d;
    logic        moving_q, moving_d;
    logic        goal_q, goal_d;
    logic [1:0]  lvl_q;
    logic        pos_valid_q;
    logic [10:0] blkpos_x_q, blkpos_x_d, blkpos_y_q, blkpos_y_d;

    logic        level_change;
    logic        blocked;
    logic [4:0]  next_row, next_col;
    logic [11:0] target, mag_step;
    logic [11:0] dx, dy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            btn_prev_q <= '0;
        end else begin
            btn_meta_q <= {btn_up, btn_down, btn_left, btn_right};
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    assign press        = btn_sync_q & ~btn_prev_q;
    assign level_change = (level_select != lvl_q);

    always_comb begin
        dx = '0;
        dy = '0;
        unique case (dir_q)
            DIR_UP:    dy = -mag_q;
            DIR_DOWN:  dy = mag_q;
            DIR_LEFT:  dx = -mag_q;
            DIR_RIGHT: dx = mag_q;
        endcase
        blkpos_x_d = axis_pos(col_q, tile_w, dx, 0);
        blkpos_y_d = axis_pos(row_q, tile_h, dy, Y_ORIGIN);
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        row_d    = row_q;
        col_d    = col_q;
        q_row_d  = q_row_q;
        q_col_d  = q_col_q;
        mag_d    = mag_q;
        moving_d = moving_q;
        goal_d   = 1'b0;
        blocked  = 1'b0;
        next_row = row_q;
        next_col = col_q;
        target   = {2'b00, tile_h};
        mag_step = mag_q + STEP_L;

        unique case (dir_q)
            DIR_UP: begin
                blocked  = wall_if.q_walls[3] || (row_q == 5'd0);
                next_row = row_q - 5'd1;
            end
            DIR_DOWN: begin
                blocked  = wall_if.q_walls[2] || (row_q == num_rows - 5'd1);
                next_row = row_q + 5'd1;
            end
            DIR_LEFT: begin
                blocked  = wall_if.q_walls[1] || (col_q == 5'd0);
                next_col = col_q - 5'd1;
                target   = {2'b00, tile_w};
            end
            DIR_RIGHT: begin
                blocked  = wall_if.q_walls[0] || (col_q == num_cols - 5'd1);
                next_col = col_q + 5'd1;
                target   = {2'b00, tile_w};
            end
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (|press) begin
                    if (press[3])      dir_d = DIR_UP;
                    else if (press[2]) dir_d = DIR_DOWN;
                    else if (press[1]) dir_d = DIR_LEFT;
                    else               dir_d = DIR_RIGHT;
                    q_row_d = row_q;
                    q_col_d = col_q;
                    state_d = S_QUERY;
                end
            end
            S_QUERY: state_d = S_CHECK;
            S_CHECK: begin
                if (blocked) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_MOVE;
                    moving_d = 1'b1;
                end
            end
            S_MOVE: begin
                if (frame_tick) begin
                    if (mag_step >= target) begin
                        // Tile and offset change together, so the drawn position is continuous.
                        row_d    = next_row;
                        col_d    = next_col;
                        mag_d    = '0;
                        moving_d = 1'b0;
                        state_d  = S_IDLE;
                        goal_d   = (next_row == num_rows - 5'd1) && (next_col == num_cols - 5'd1);
                    end else begin
                        mag_d = mag_step;
                    end
                end
            end
        endcase

        if (level_change) begin
            state_d  = S_IDLE;
            row_d    = START_ROW_L;
            col_d    = START_COL_L;
            mag_d    = '0;
            moving_d = 1'b0;
            goal_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            dir_q       <= DIR_UP;
            row_q       <= START_ROW_L;
            col_q       <= START_COL_L;
            q_row_q     <= START_ROW_L;
            q_col_q     <= START_COL_L;
            mag_q       <= '0;
            moving_q    <= 1'b0;
            goal_q      <= 1'b0;
            lvl_q       <= '0;
            pos_valid_q <= 1'b0;
            blkpos_x_q  <= '0;
            blkpos_y_q  <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            row_q       <= row_d;
            col_q       <= col_d;
            q_row_q     <= q_row_d;
            q_col_q     <= q_col_d;
            mag_q       <= mag_d;
            moving_q    <= moving_d;
            goal_q      <= goal_d;
            lvl_q       <= level_select;
            pos_valid_q <= 1'b1;
            blkpos_x_q  <= blkpos_x_d;
            blkpos_y_q  <= blkpos_y_d;
        end
    end

    // Until the position register has loaded once after reset, show the start tile directly.
    assign blkpos_x = pos_valid_q ? blkpos_x_q : axis_pos(START_COL_L, tile_w, 12'd0, 0);
    assign blkpos_y = pos_valid_q ? blkpos_y_q : axis_pos(START_ROW_L, tile_h, 12'd0, Y_ORIGIN);

    assign wall_if.q_row = q_row_q;
    assign wall_if.q_col = q_col_q;
    assign moving        = moving_q;
    assign goal_pulse    = goal_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed bench for maze_player_ctrl: a table of single-move vectors on an 8x8
// grid of 64-pixel tiles, then hand-written animation, level-change and reset sequences.
module tb_maze_player_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn;
    logic        frame_tick;
    logic [1:0]  level_select;
    logic [9:0]  tile_w, tile_h;
    logic [4:0]  num_rows, num_cols;
    logic [3:0]  walls_now;
    logic [10:0] blkpos_x, blkpos_y;
    logic        moving, goal_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    maze_player_ctrl_if wif ();
    assign wif.q_walls = walls_now;

    maze_player_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up       (btn[3]),
        .btn_down     (btn[2]),
        .btn_left     (btn[1]),
        .btn_right    (btn[0]),
        .frame_tick   (frame_tick),
        .level_select (level_select),
        .tile_w       (tile_w),
        .tile_h       (tile_h),
        .num_rows     (num_rows),
        .num_cols     (num_cols),
        .wall_if      (wif),
        .blkpos_x     (blkpos_x),
        .blkpos_y     (blkpos_y),
        .moving       (moving),
        .goal_pulse   (goal_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] walls;
        int         exp_x;
        int         exp_y;
        int         exp_moved;
        int         exp_goals;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        step(3);
        btn = 4'b0000;
    endtask

    task automatic wait_moving(input string name);
        bit seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (moving) begin
                seen = 1;
                break;
            end
        end
        check(name, int'(seen), 1);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
    endtask

    initial begin
        //         btn      walls    x    y    moved goals
        vecs[0]  = '{4'b1000, 4'b0000,  27, 127, 0, 0};  // up at row 0
        vecs[1]  = '{4'b0010, 4'b0000,  27, 127, 0, 0};  // left at col 0
        vecs[2]  = '{4'b0001, 4'b0001,  27, 127, 0, 0};  // right wall
        vecs[3]  = '{4'b0001, 4'b0000,  91, 127, 1, 0};
        vecs[4]  = '{4'b0100, 4'b0100,  91, 127, 0, 0};  // bottom wall
        vecs[5]  = '{4'b0100, 4'b1011,  91, 191, 1, 0};  // only bottom open
        vecs[6]  = '{4'b1010, 4'b0000,  91, 127, 1, 0};  // up beats left
        vecs[7]  = '{4'b0111, 4'b0000,  91, 191, 1, 0};  // down beats left/right
        vecs[8]  = '{4'b0011, 4'b0010,  91, 191, 0, 0};  // left beats right, left wall
        vecs[9]  = '{4'b0001, 4'b0000, 155, 191, 1, 0};
        vecs[10] = '{4'b0010, 4'b0000,  91, 191, 1, 0};
        vecs[11] = '{4'b0100, 4'b0000,  91, 255, 1, 0};
        vecs[12] = '{4'b0100, 4'b0000,  91, 319, 1, 0};
        vecs[13] = '{4'b0001, 4'b0000, 155, 319, 1, 0};
        vecs[14] = '{4'b0001, 4'b0000, 219, 319, 1, 0};  // at (3,3)
        vecs[15] = '{4'b1010, 4'b0000, 219, 255, 1, 0};  // up+left -> up only
        vecs[16] = '{4'b0100, 4'b0000, 219, 319, 1, 0};
        vecs[17] = '{4'b0100, 4'b0000, 219, 383, 1, 0};
        vecs[18] = '{4'b0100, 4'b0000, 219, 447, 1, 0};
        vecs[19] = '{4'b0100, 4'b0000, 219, 511, 1, 0};
        vecs[20] = '{4'b0100, 4'b0000, 219, 575, 1, 0};
        vecs[21] = '{4'b0001, 4'b0000, 283, 575, 1, 0};
        vecs[22] = '{4'b0001, 4'b0000, 347, 575, 1, 0};
        vecs[23] = '{4'b0001, 4'b0000, 411, 575, 1, 0};  // at (7,6)
        vecs[24] = '{4'b0001, 4'b0000, 475, 575, 1, 1};  // goal (7,7)
        vecs[25] = '{4'b0001, 4'b0000, 475, 575, 0, 0};  // right edge
        vecs[26] = '{4'b0100, 4'b0000, 475, 575, 0, 0};  // bottom edge

        rst          = 1'b0;
        btn          = 4'b0000;
        frame_tick   = 1'b0;
        level_select = 2'd0;
        tile_w       = 10'd64;
        tile_h       = 10'd64;
        num_rows     = 5'd8;
        num_cols     = 5'd8;
        walls_now    = 4'b0000;

        // Reset state, both while held and after release.
        #3;
        check("rst_x", blkpos_x, 27);
        check("rst_y", blkpos_y, 127);
        check("rst_moving", moving, 0);
        check("rst_goal", goal_pulse, 0);
        check("rst_q_row", wif.q_row, 0);
        check("rst_q_col", wif.q_col, 0);
        #20 rst = 1'b1;
        step(2);
        check("post_rst_x", blkpos_x, 27);
        check("post_rst_y", blkpos_y, 127);

        // Table of single moves with frame ticks every other cycle.
        for (int i = 0; i < NV; i++) begin
            int  goals;
            bit  moved, coinc_ok, prev_mov;
            walls_now = vecs[i].walls;
            press(vecs[i].btn);
            moved = 0; goals = 0; coinc_ok = 1; prev_mov = moving;
            for (int c = 0; c < 100; c++) begin
                frame_tick = (c % 2 == 0);
                step(1);
                if (moving) moved = 1;
                if (goal_pulse) begin
                    goals++;
                    if (moving || !prev_mov) coinc_ok = 0;
                end
                prev_mov = moving;
            end
            frame_tick = 1'b0;
            step(2);
            check($sformatf("vec%0d_x", i), blkpos_x, vecs[i].exp_x);
            check($sformatf("vec%0d_y", i), blkpos_y, vecs[i].exp_y);
            check($sformatf("vec%0d_moved", i), int'(moved), vecs[i].exp_moved);
            check($sformatf("vec%0d_goals", i), goals, vecs[i].exp_goals);
            check($sformatf("vec%0d_idle", i), moving, 0);
            if (goals > 0) check($sformatf("vec%0d_goal_with_fall", i), int'(coinc_ok), 1);
        end

        // Fresh start, then a tick-by-tick right move with a dropped mid-move press.
        walls_now = 4'b0000;
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(2);
        press(4'b0001);
        wait_moving("anim_start");
        for (int k = 1; k <= 32; k++) begin
            if (k == 3) btn = 4'b0100;
            if (k == 6) btn = 4'b0000;
            tick();
            check($sformatf("anim_x_tick%0d", k), blkpos_x, (k < 32) ? 27 + 2 * k : 91);
            if (k == 31) check("anim_moving_tick31", moving, 1);
        end
        check("anim_moving_done", moving, 0);
        repeat (4) tick();
        check("idle_ticks_x", blkpos_x, 91);
        check("dropped_press_y", blkpos_y, 127);
        check("dropped_press_moving", moving, 0);

        // Level change mid-move restarts at the start tile with the new tile size.
        press(4'b0001);
        wait_moving("lvl_move_start");
        repeat (10) tick();
        check("lvl_mid_x", blkpos_x, 111);
        level_select = 2'd1;
        tile_w       = 10'd32;
        tile_h       = 10'd32;
        step(2);
        check("lvl_x", blkpos_x, 11);
        check("lvl_y", blkpos_y, 111);
        check("lvl_moving", moving, 0);
        begin
            bit bad = 0;
            for (int c = 0; c < 12; c++) begin
                frame_tick = (c % 2 == 0);
                step(1);
                if (goal_pulse || moving) bad = 1;
            end
            frame_tick = 1'b0;
            check("lvl_quiet", int'(bad), 0);
        end
        check("lvl_hold_x", blkpos_x, 11);

        // Asynchronous reset mid-move.
        press(4'b0001);
        wait_moving("rst_move_start");
        repeat (5) tick();
        check("rst_mid_x", blkpos_x, 21);
        #2 rst = 1'b0;
        #1;
        check("arst_x", blkpos_x, 11);
        check("arst_y", blkpos_y, 111);
        check("arst_moving", moving, 0);
        check("arst_goal", goal_pulse, 0);
        check("arst_q_row", wif.q_row, 0);
        check("arst_q_col", wif.q_col, 0);
        #10 rst = 1'b1;
        step(3);
        check("arst_after_x", blkpos_x, 11);
        check("arst_after_moving", moving, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
